// File: rtl/reg_lock_scoreboard.sv
// Register-lock scoreboard: holds per-register locks and memory-busy state fed back
// into the grant checker, with a global all-locked state while a blocking op is in flight.

package maverickOne_pkg;
   localparam int unsigned NUM_REGS = 32;
endpackage

module reg_lock_scoreboard #(
   parameter int unsigned NR  = maverickOne_pkg::NUM_REGS,
   parameter int unsigned NWB = 2
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             issue_valid_i,
   input  logic                             issue_blocking_i,
   input  logic [$clog2(NR)-1:0]            issue_rd_i,
   input  logic [NR-1:0]                    issue_locks_i,
   input  logic                             issue_mem_busy_i,
   input  logic [NWB-1:0]                   wb_valid_i,
   input  logic [NWB-1:0][$clog2(NR)-1:0]   wb_rd_i,
   input  logic                             mem_done_i,
   input  logic                             blk_done_i,
   input  logic                             flush_i,
   output logic [NR-1:0]                    locks_o,
   output logic                             mem_busy_o,
   output logic                             blocked_o,
   output logic                             idle_o
);

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_BLOCKED = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [NR-1:0]   lock_q, lock_d;
   logic            mem_q, mem_d;
   logic [NR-1:0]   wb_mask;
   logic [NR-1:0]   rd_bit;
   logic            issue_acc;

   // Registers cleared by any valid writeback port; register 0 never holds a lock.
   always_comb begin
      wb_mask = '0;
      for (int unsigned p = 0; p < NWB; p++) begin
         if (wb_valid_i[p]) begin
            wb_mask = wb_mask | (NR'(1) << wb_rd_i[p]);
         end
      end
      wb_mask[0] = 1'b0;
   end

   assign rd_bit    = (issue_rd_i != '0) ? (NR'(1) << issue_rd_i) : '0;
   assign issue_acc = (state_q == ST_RUN) && issue_valid_i;

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; blk_done_i only matters once BLOCKED
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_RUN: begin
            if (issue_valid_i && issue_blocking_i) begin
               state_d = ST_BLOCKED;
            end
         end
         ST_BLOCKED: begin
            if (blk_done_i) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
      if (flush_i) begin
         state_d = ST_RUN;
      end
   end

   // Lock vector and memory flag update; a same-cycle set beats a clear
   always_comb begin
      lock_d = lock_q & ~wb_mask;
      mem_d  = mem_q & ~mem_done_i;
      if (issue_acc) begin
         if (!issue_blocking_i) begin
            lock_d = (issue_locks_i & ~wb_mask) | rd_bit;
         end
         mem_d = mem_d | issue_mem_busy_i;
      end
      lock_d[0] = 1'b0;
      if (flush_i) begin
         lock_d = '0;
         mem_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lock_q <= '0;
         mem_q  <= 1'b0;
      end else begin
         lock_q <= lock_d;
         mem_q  <= mem_d;
      end
   end

   // Outputs decoded from registers only, so no loop through the checker
   always_comb begin
      locks_o    = (state_q == ST_BLOCKED) ? '1 : lock_q;
      mem_busy_o = mem_q;
      blocked_o  = (state_q == ST_BLOCKED);
      idle_o     = (state_q == ST_RUN) && (lock_q == '0) && !mem_q;
   end

endmodule

// File: doc/reg_lock_scoreboard.md
# reg_lock_scoreboard

Sequential register-lock state holder that closes the loop around `reg_gnt_ckr`. It stores the per-register lock vector and the memory-busy flag, drives them into the checker's `locks_i` / `mem_busy_i`, and loads the checker's `locks_o` / `mem_busy_o` when an instruction issues. It clears locks on writeback and memory completion, and holds a global all-locked state while a blocking instruction is in flight.

## Interface

- `NR`, default `maverickOne_pkg::NUM_REGS`: number of architectural registers.
- `NWB`, default `2`: number of writeback ports.

Clock/reset: one clock; reset is synchronous and active-high.

- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: synchronous active-high reset.
- `issue_valid_i` in 1: an instruction granted by arbitration issues this cycle.
- `issue_blocking_i` in 1: the issuing instruction is blocking.
- `issue_rd_i` in `$clog2(NR)`: destination register of the issuing instruction.
- `issue_locks_i` in `NR`: `locks_o` from `reg_gnt_ckr` for the issuing instruction.
- `issue_mem_busy_i` in 1: `mem_busy_o` from `reg_gnt_ckr`.
- `wb_valid_i` in `NWB`: per-port writeback valid.
- `wb_rd_i` in `NWB` x `$clog2(NR)`: per-port writeback destination.
- `mem_done_i` in 1: the outstanding memory operation completed.
- `blk_done_i` in 1: the in-flight blocking instruction retired.
- `flush_i` in 1: pipeline flush.
- `locks_o` out `NR`: to `reg_gnt_ckr.locks_i`.
- `mem_busy_o` out 1: to `reg_gnt_ckr.mem_busy_i`.
- `blocked_o` out 1: FSM is in BLOCKED.
- `idle_o` out 1: no locks, not blocked, memory not busy.

## Operation

State:
- `lock_q[NR]`: tracked locks.
- `mem_q`: memory-busy flag.
- FSM `{RUN, BLOCKED}`.

Outputs are all registered or derived from registers:
- `locks_o = BLOCKED ? '1 : lock_q`.
- `mem_busy_o = mem_q`.
- `blocked_o = (state == BLOCKED)`.
- `idle_o = RUN & ~|lock_q & ~mem_q`.

Writeback mask:
- `wb_mask` is the OR over ports `p` of `wb_valid_i[p] ? (1 << wb_rd_i[p]) : 0`.
- Duplicate indices across ports are harmless.
- Writebacks to register 0 are ignored.

In RUN:
- **Normal issue** (`issue_valid_i & ~issue_blocking_i`):
  - `lock_q <= (issue_locks_i & ~wb_mask) | rd_bit`, where `rd_bit = 1 << issue_rd_i` when `issue_rd_i != 0`, else 0.
  - A set of `rd` wins over a same-cycle clear of that register.
- **Blocking issue** (`issue_valid_i & issue_blocking_i`):
  - `lock_q <= lock_q & ~wb_mask`; `issue_locks_i` (all-ones) is not stored.
  - FSM moves to BLOCKED.
  - `mem_q` is updated as for a normal issue.
- **No issue:** `lock_q <= lock_q & ~wb_mask`.

In BLOCKED:
- `issue_valid_i` is ignored; the checker cannot grant because `locks_o` is all ones.
- Writebacks continue clearing `lock_q`.
- `blk_done_i` returns the FSM to RUN. The next cycle `locks_o` shows the underlying `lock_q`.

`mem_q`:
- Next value is `(issue accepted & issue_mem_busy_i) | (mem_q & ~mem_done_i)`.
- A set wins over a same-cycle `mem_done_i`.

Register 0:
- `lock_q[0]` is held at 0 in every update, including when `issue_locks_i[0]` is 1.
- `locks_o[0]` is 1 only in BLOCKED.

Flush and reset:
- `flush_i` has priority over issue, writeback and done.
- Effect of `flush_i`: `lock_q <= 0`, `mem_q <= 0`, FSM to RUN.
- `rst_i` has the same effect and highest priority.

## Timing

- Reset values: `locks_o = 0`, `mem_busy_o = 0`, `blocked_o = 0`, `idle_o = 1`.
- Latency is 1 cycle from every input to the affected output. An issue at edge N is visible on `locks_o` after edge N.
- No combinational path from any input to any output. This avoids a loop through the combinational `reg_gnt_ckr`.
- `blk_done_i` in RUN is ignored. `mem_done_i` with `mem_q = 0` is ignored.
- Reset or flush asserted mid-BLOCKED: the next cycle is RUN with all locks clear.
- Simultaneous blocking issue and `blk_done_i` in RUN: enter BLOCKED, since `blk_done_i` applies only in BLOCKED.

## Test plan

- **Reset:** assert `rst_i` 2 cycles with random inputs → `locks_o = 0`, `mem_busy_o = 0`, `blocked_o = 0`, `idle_o = 1`.
- **Issue then writeback:**
  - Issue with `issue_rd_i = 5` and `issue_locks_i = 1<<5` → `locks_o = 1<<5` next cycle, `idle_o = 0`.
  - Then `wb_valid_i[1] = 1`, `wb_rd_i[1] = 5` → `locks_o = 0`, `idle_o = 1`.
- **Same-cycle conflict and dual writeback:**
  - Start with `lock_q = (1<<3) | (1<<7)`.
  - Issue `rd = 3` with `issue_locks_i = (1<<3) | (1<<7)`, same cycle as writebacks to 3 and 7 → `locks_o = 1<<3`.
- **Register 0:** issue with `rd = 0` and `issue_locks_i = 1` → `locks_o = 0`.
- **Blocking:**
  - With `lock_q = 1<<9`, a blocking issue → `locks_o = '1`, `blocked_o = 1`.
  - A normal issue during BLOCKED is ignored.
  - Writeback to 9, then `blk_done_i` → `locks_o = 0`, `blocked_o = 0`.
- **Memory flag and flush:**
  - Issue with `issue_mem_busy_i = 1` → `mem_busy_o = 1`.
  - Same cycle `mem_done_i` plus a new mem issue → stays 1.
  - `mem_done_i` alone → 0.
  - `flush_i` during BLOCKED with locks set → all outputs return to reset values next cycle.
